regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
//   Shares the single register-file write port (we/a3/wd3) between the ALU
//   writeback path and the load/store-unit (LSU) return path using round-robin
//   arbitration. Keeps a per-register busy scoreboard so the issue stage
//   stalls on RAW/WAW hazards against writes that have not yet reached the
//   register file. Sits between the execute/LSU stages and register_file_module.
// PARAMETERS
//   XLEN      32  data width of write data
//   NREGS     32  number of architectural registers (x0 hard-wired zero)
//   AW        5   register index width, log2(NREGS)
// PORTS
//   clk           in   1     clock; all state updates on posedge
//   reset         in   1     asynchronous, active-high reset
//   issue_valid   in   1     issue stage presents an instruction
//   issue_rs1     in   AW    source register 1
//   issue_rs2     in   AW    source register 2
//   issue_rd      in   AW    destination register (0 = no writeback)
//   issue_ready   out  1     1 = no hazard, instruction may issue this cycle
//   alu_wb_valid  in   1     ALU writeback request
//   alu_wb_rd     in   AW    ALU destination register
//   alu_wb_data   in   XLEN  ALU result
//   alu_wb_ready  out  1     ALU request granted this cycle
//   lsu_wb_valid  in   1     LSU load-return request
//   lsu_wb_rd     in   AW    LSU destination register
//   lsu_wb_data   in   XLEN  load data
//   lsu_wb_ready  out  1     LSU request granted this cycle
//   rf_we         out  1     register-file write enable (registered)
//   rf_a3         out  AW    register-file write index (registered)
//   rf_wd3        out  XLEN  register-file write data (registered)
//   busy_mask     out  NREGS scoreboard, bit i = write to xi outstanding
// BEHAVIOUR
//   Reset: rf_we=0, rf_a3=0, rf_wd3=0, busy_mask=0, rr pointer favours ALU.
//   Reset mid-operation: any granted write held in the output register is
//   dropped (rf_we forced 0); scoreboard cleared; requesters must re-issue.
//   Arbitration (combinational, from registered rr pointer):
//   - only one valid -> grant it; both valid -> grant side not granted last.
//   - rr pointer updates only on a grant; ready = grant, single-cycle accept.
//   - no grant when neither valid; ready outputs are 0.
//   Write stage: 1-cycle latency. Grant in cycle N -> rf_we=1, rf_a3/rf_wd3
//   = granted rd/data in cycle N+1; register file commits at end of N+1.
//   - granted rd==0: accepted (ready=1) but rf_we stays 0 in N+1.
//   - no grant in N: rf_we=0 in N+1; rf_a3/rf_wd3 hold previous values.
//   Scoreboard:
//   - set busy[rd] at edge where issue_valid & issue_ready & rd!=0.
//   - clear busy[rf_a3] at the edge ending a cycle with rf_we=1.
//   - busy[0] is constant 0.
//   - writeback to a non-busy rd: still written; busy unchanged (protocol
//     error, flagged by simulation assertion only).
//   issue_ready = ~(busy[rs1] | busy[rs2] | busy[rd]) using registered busy
//   only; no same-cycle bypass from rf_we. issue_ready is independent of
//   issue_valid. Set and clear of the same bit in one cycle cannot occur
//   (WAW stall); if forced, set wins.
//   Earliest reuse: rd released at end of N+1 -> dependent issue in N+2.
// TESTING
//   1 reset asserted mid-run -> rf_we=0, busy_mask=0 same cycle, ALU
//     granted first after release when both request.
//   2 issue rd=5 -> busy_mask=0x20; issue rs1=5 stalls (issue_ready=0);
//     ALU wb rd=5 data=0xAABBCCDD granted N -> rf_we=1,a3=5 N+1; ready N+2.
//   3 ALU and LSU valid every cycle (rd=3,4) -> grants alternate A,L,A,L;
//     rf_a3 sequence 3,4,3,4 from cycle 1 with 1-cycle lag.
//   4 LSU-only wb rd=0 data=0x1234 -> lsu_wb_ready=1, rf_we stays 0,
//     busy_mask unchanged.
//   5 issue rd=7 while busy[7]=1 (WAW) -> issue_ready=0 until write of x7
//     commits; busy[7] re-set on the next issue.
//   6 grant in N then reset in N+1 -> rf_we=0, no write of granted value.

Source files
------------

// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of the signals between the execute/LSU stages and the register-file
// writeback scheduler.
//   master : issue stage, ALU writeback and LSU return path (drive requests)
//   slave  : regfile_wb_scheduler (grants, register-file write port, busy_mask)
// Signals:
//   issue_valid/rs1/rs2/rd -> issue_ready         issue-stage hazard query
//   alu_wb_valid/rd/data   -> alu_wb_ready        ALU writeback request/grant
//   lsu_wb_valid/rd/data   -> lsu_wb_ready        LSU load-return request/grant
//   rf_we/rf_a3/rf_wd3                            register-file write port
//   busy_mask                                     outstanding-write scoreboard
interface regfile_wb_scheduler_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
);
  logic             issue_valid;
  logic [AW-1:0]    issue_rs1;
  logic [AW-1:0]    issue_rs2;
  logic [AW-1:0]    issue_rd;
  logic             issue_ready;

  logic             alu_wb_valid;
  logic [AW-1:0]    alu_wb_rd;
  logic [XLEN-1:0]  alu_wb_data;
  logic             alu_wb_ready;

  logic             lsu_wb_valid;
  logic [AW-1:0]    lsu_wb_rd;
  logic [XLEN-1:0]  lsu_wb_data;
  logic             lsu_wb_ready;

  logic             rf_we;
  logic [AW-1:0]    rf_a3;
  logic [XLEN-1:0]  rf_wd3;
  logic [NREGS-1:0] busy_mask;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
    input  issue_ready,
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  alu_wb_ready,
    output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    input  lsu_wb_ready,
    input  rf_we, rf_a3, rf_wd3, busy_mask
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
    output issue_ready,
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    output alu_wb_ready,
    input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    output lsu_wb_ready,
    output rf_we, rf_a3, rf_wd3, busy_mask
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
// Shares the single register-file write port between the ALU writeback path
// and the LSU load-return path with round-robin arbitration, and keeps a
// per-register busy scoreboard so the issue stage stalls on RAW/WAW hazards
// against writes that have not reached the register file yet.
// Ports:
//   clk    in  clock, all state updates on posedge
//   reset  in  asynchronous, active-high reset
//   bus    slave modport of regfile_wb_scheduler_if:
//          issue_* (hazard query), alu_wb_* / lsu_wb_* (writeback requests,
//          ready = grant), rf_we/rf_a3/rf_wd3 (registered write port),
//          busy_mask (bit i = write to xi outstanding)
module regfile_wb_scheduler #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_scheduler_if.slave bus
);

  localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

  // Round-robin state: 1 = ALU wins the next two-way contention.
  logic             favour_alu_p1;

  logic             grant_alu;
  logic             grant_lsu;
  logic             grant_any;
  logic [AW-1:0]    grant_rd;
  logic [XLEN-1:0]  grant_data;

  logic             vld_p1;
  logic [AW-1:0]    rd_p1;
  logic [XLEN-1:0]  data_p1;

  logic [NREGS-1:0] busy_p1;
  logic [NREGS-1:0] busy_set;
  logic [NREGS-1:0] busy_clr;
  logic [NREGS-1:0] busy_next;
  logic             issue_ok;
  logic             issue_fire;

  // Stage p0: arbitration and hazard check (combinational from registered state)
  always_comb begin
    grant_alu  = bus.alu_wb_valid & (~bus.lsu_wb_valid | favour_alu_p1);
    grant_lsu  = bus.lsu_wb_valid & (~bus.alu_wb_valid | ~favour_alu_p1);
    grant_any  = grant_alu | grant_lsu;
    grant_rd   = grant_alu ? bus.alu_wb_rd   : bus.lsu_wb_rd;
    grant_data = grant_alu ? bus.alu_wb_data : bus.lsu_wb_data;
  end

  // Only the registered scoreboard is consulted: a write committing this
  // cycle releases its register for issue in the following cycle.
  always_comb begin
    issue_ok   = ~(busy_p1[bus.issue_rs1] | busy_p1[bus.issue_rs2] |
                   busy_p1[bus.issue_rd]);
    issue_fire = bus.issue_valid & issue_ok & (bus.issue_rd != '0);
  end

  // Set is applied after clear so a forced same-bit collision leaves it busy.
  always_comb begin
    busy_set     = issue_fire ? (ONE_HOT0 << bus.issue_rd) : '0;
    busy_clr     = vld_p1     ? (ONE_HOT0 << rd_p1)        : '0;
    busy_next    = (busy_p1 & ~busy_clr) | busy_set;
    busy_next[0] = 1'b0;
  end

  // Stage p1: write-port register and scoreboard
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      favour_alu_p1 <= 1'b1;
      vld_p1        <= 1'b0;
      rd_p1         <= '0;
      data_p1       <= '0;
      busy_p1       <= '0;
    end else begin
      if (grant_any) begin
        favour_alu_p1 <= grant_lsu;
        rd_p1         <= grant_rd;
        data_p1       <= grant_data;
      end
      // A granted write to x0 is accepted but never drives the write port.
      vld_p1  <= grant_any & (grant_rd != '0);
      busy_p1 <= busy_next;
    end
  end

  assign bus.issue_ready  = issue_ok;
  assign bus.alu_wb_ready = grant_alu;
  assign bus.lsu_wb_ready = grant_lsu;
  assign bus.rf_we        = vld_p1;
  assign bus.rf_a3        = rd_p1;
  assign bus.rf_wd3       = data_p1;
  assign bus.busy_mask    = busy_p1;

  // A committing write should always target a register marked busy; anything
  // else means a writeback arrived without a matching issue.
  a_wb_target_busy: assert property (
    @(posedge clk) disable iff (reset) vld_p1 |-> busy_p1[rd_p1]
  );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

  logic clk;
  logic reset;

  regfile_wb_scheduler_if bus ();

  regfile_wb_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: which registers have an outstanding write, which side
  // won the last contested grant, and what the write port shows next cycle.
  logic [31:0] m_busy;
  bit          m_favour_alu;
  logic        m_we;
  int          m_a3;
  logic [31:0] m_wd3;
  int          pool[$];   // busy registers whose write has not been granted yet

  // Observed (sampled at negedge) and expected values for the current cycle.
  logic        o_ir, o_ar, o_lr, o_we;
  int          o_a3;
  logic [31:0] o_wd3, o_busy;
  logic        e_ir, e_ar, e_lr, e_we;
  int          e_a3;
  logic [31:0] e_wd3, e_busy;

  function automatic void pool_remove(int r);
    for (int i = 0; i < pool.size(); i++) begin
      if (pool[i] == r) begin
        pool.delete(i);
        return;
      end
    end
  endfunction

  task automatic clear_inputs();
    bus.issue_valid  = 1'b0;
    bus.issue_rs1    = '0;
    bus.issue_rs2    = '0;
    bus.issue_rd     = '0;
    bus.alu_wb_valid = 1'b0;
    bus.alu_wb_rd    = '0;
    bus.alu_wb_data  = '0;
    bus.lsu_wb_valid = 1'b0;
    bus.lsu_wb_rd    = '0;
    bus.lsu_wb_data  = '0;
  endtask

  task automatic model_reset();
    m_busy       = '0;
    m_favour_alu = 1'b1;
    m_we         = 1'b0;
    m_a3         = 0;
    m_wd3        = '0;
    pool.delete();
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // One clock cycle: called at posedge+1, drives inputs, samples at negedge,
  // returns at the next posedge+1 with the model advanced across that edge.
  task automatic cycle(input int iv, input int rs1, input int rs2, input int rd,
                       input int av, input int ard, input logic [31:0] ad,
                       input int lv, input int lrd, input logic [31:0] ld);
    int          g_rd;
    logic [31:0] g_d;
    bus.issue_valid  = (iv != 0);
    bus.issue_rs1    = 5'(rs1);
    bus.issue_rs2    = 5'(rs2);
    bus.issue_rd     = 5'(rd);
    bus.alu_wb_valid = (av != 0);
    bus.alu_wb_rd    = 5'(ard);
    bus.alu_wb_data  = ad;
    bus.lsu_wb_valid = (lv != 0);
    bus.lsu_wb_rd    = 5'(lrd);
    bus.lsu_wb_data  = ld;
    e_ir = !(m_busy[rs1] || m_busy[rs2] || m_busy[rd]);
    if (av != 0 && lv != 0) begin
      e_ar = m_favour_alu;
      e_lr = !m_favour_alu;
    end else begin
      e_ar = (av != 0);
      e_lr = (lv != 0);
    end
    e_we   = m_we;
    e_a3   = m_a3;
    e_wd3  = m_wd3;
    e_busy = m_busy;
    #4;
    o_ir   = bus.issue_ready;
    o_ar   = bus.alu_wb_ready;
    o_lr   = bus.lsu_wb_ready;
    o_we   = bus.rf_we;
    o_a3   = int'(bus.rf_a3);
    o_wd3  = bus.rf_wd3;
    o_busy = bus.busy_mask;
    @(posedge clk);
    #1;
    if (m_we) m_busy[m_a3] = 1'b0;
    if (iv != 0 && e_ir && rd != 0) begin
      m_busy[rd] = 1'b1;
      pool.push_back(rd);
    end
    if (e_ar || e_lr) begin
      g_rd  = e_ar ? ard : lrd;
      g_d   = e_ar ? ad : ld;
      m_we  = (g_rd != 0);
      m_a3  = g_rd;
      m_wd3 = g_d;
      m_favour_alu = e_lr;
      pool_remove(g_rd);
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic iss(input int rd);
    cycle(1, 0, 0, rd, 0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (bus.rf_we !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.rf_we); else n_pass++;
    n_checks++; if (bus.rf_a3 !== 5'd0) $display("FAIL reset_a3: got %0d want 0", bus.rf_a3); else n_pass++;
    n_checks++; if (bus.rf_wd3 !== 32'h0) $display("FAIL reset_wd3: got %h want 0", bus.rf_wd3); else n_pass++;
    n_checks++; if (bus.busy_mask !== 32'h0) $display("FAIL reset_busy: got %h want 0", bus.busy_mask); else n_pass++;
    n_checks++; if (bus.alu_wb_ready !== 1'b0 || bus.lsu_wb_ready !== 1'b0)
      $display("FAIL reset_ready: got alu=%b lsu=%b want 0 0", bus.alu_wb_ready, bus.lsu_wb_ready); else n_pass++;
    n_checks++; if (bus.issue_ready !== 1'b1) $display("FAIL reset_issue_ready: got %b want 1", bus.issue_ready); else n_pass++;
  endtask

  task automatic test_raw_stall();
    iss(5);
    n_checks++; if (o_ir !== 1'b1) $display("FAIL raw_first_issue: got %b want 1", o_ir); else n_pass++;
    cycle(1, 5, 0, 6, 1, 5, 32'hAABBCCDD, 0, 0, 32'h0);
    n_checks++; if (o_busy !== 32'h20) $display("FAIL raw_busy: got %h want 00000020", o_busy); else n_pass++;
    n_checks++; if (o_ir !== 1'b0) $display("FAIL raw_stall_n: got %b want 0", o_ir); else n_pass++;
    n_checks++; if (o_ar !== 1'b1) $display("FAIL raw_alu_grant: got %b want 1", o_ar); else n_pass++;
    cycle(1, 5, 0, 6, 0, 0, 32'h0, 0, 0, 32'h0);
    n_checks++; if (o_ir !== 1'b0) $display("FAIL raw_stall_n1: got %b want 0", o_ir); else n_pass++;
    n_checks++; if (o_we !== 1'b1 || o_a3 !== 5 || o_wd3 !== 32'hAABBCCDD)
      $display("FAIL raw_write: got we=%b a3=%0d wd3=%h want 1 5 aabbccdd", o_we, o_a3, o_wd3); else n_pass++;
    cycle(1, 5, 0, 6, 0, 0, 32'h0, 0, 0, 32'h0);
    n_checks++; if (o_ir !== 1'b1 || o_we !== 1'b0 || o_busy !== 32'h0)
      $display("FAIL raw_release: got ir=%b we=%b busy=%h want 1 0 0", o_ir, o_we, o_busy); else n_pass++;
    cycle(0, 0, 0, 0, 1, 6, 32'h66, 0, 0, 32'h0);
    idle();
    idle();
    n_checks++; if (o_busy !== 32'h0) $display("FAIL raw_drain: got %h want 0", o_busy); else n_pass++;
  endtask

  task automatic test_rd_zero();
    cycle(0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h1234);
    n_checks++; if (o_lr !== 1'b1 || o_ar !== 1'b0)
      $display("FAIL rd0_grant: got lsu=%b alu=%b want 1 0", o_lr, o_ar); else n_pass++;
    idle();
    n_checks++; if (o_we !== 1'b0) $display("FAIL rd0_we: got %b want 0", o_we); else n_pass++;
    n_checks++; if (o_busy !== 32'h0) $display("FAIL rd0_busy: got %h want 0", o_busy); else n_pass++;
  endtask

  task automatic test_alternation();
    iss(3);
    iss(4);
    for (int k = 0; k < 6; k++) begin
      cycle((k >= 2) ? 1 : 0, 0, 0, (k % 2 == 0) ? 3 : 4,
            1, 3, 32'hA0 + 32'(k), 1, 4, 32'hB0 + 32'(k));
      n_checks++; if (o_ar !== (k % 2 == 0) || o_lr !== (k % 2 == 1))
        $display("FAIL alt_grant_%0d: got alu=%b lsu=%b want alu=%0d", k, o_ar, o_lr, (k % 2 == 0)); else n_pass++;
      if (k >= 1) begin
        n_checks++;
        if (o_we !== 1'b1 || o_a3 !== ((k % 2 == 1) ? 3 : 4) ||
            o_wd3 !== ((k % 2 == 1) ? 32'hA0 : 32'hB0) + 32'(k - 1))
          $display("FAIL alt_write_%0d: got we=%b a3=%0d wd3=%h", k, o_we, o_a3, o_wd3);
        else n_pass++;
      end
      if (k >= 2) begin
        n_checks++; if (o_ir !== 1'b1) $display("FAIL alt_reissue_%0d: got %b want 1", k, o_ir); else n_pass++;
      end
    end
    idle();
    n_checks++; if (o_we !== 1'b1 || o_a3 !== 4 || o_wd3 !== 32'hB5)
      $display("FAIL alt_last_write: got we=%b a3=%0d wd3=%h want 1 4 b5", o_we, o_a3, o_wd3); else n_pass++;
    idle();
    n_checks++; if (o_busy !== 32'h0 || o_we !== 1'b0)
      $display("FAIL alt_drain: got busy=%h we=%b want 0 0", o_busy, o_we); else n_pass++;
  endtask

  task automatic test_waw();
    iss(7);
    iss(7);
    n_checks++; if (o_ir !== 1'b0) $display("FAIL waw_stall: got %b want 0", o_ir); else n_pass++;
    cycle(1, 0, 0, 7, 1, 7, 32'h77, 0, 0, 32'h0);
    n_checks++; if (o_ir !== 1'b0 || o_ar !== 1'b1)
      $display("FAIL waw_grant: got ir=%b alu=%b want 0 1", o_ir, o_ar); else n_pass++;
    iss(7);
    n_checks++; if (o_ir !== 1'b0 || o_we !== 1'b1 || o_a3 !== 7)
      $display("FAIL waw_commit: got ir=%b we=%b a3=%0d want 0 1 7", o_ir, o_we, o_a3); else n_pass++;
    iss(7);
    n_checks++; if (o_ir !== 1'b1) $display("FAIL waw_reissue: got %b want 1", o_ir); else n_pass++;
    cycle(0, 0, 0, 0, 1, 7, 32'h78, 0, 0, 32'h0);
    n_checks++; if (o_busy !== 32'h80) $display("FAIL waw_reset_bit: got %h want 00000080", o_busy); else n_pass++;
    idle();
    idle();
    n_checks++; if (o_busy !== 32'h0) $display("FAIL waw_drain: got %h want 0", o_busy); else n_pass++;
  endtask

  task automatic test_reset_after_grant();
    iss(1);
    iss(2);
    cycle(0, 0, 0, 0, 1, 1, 32'h11111111, 0, 0, 32'h0);
    n_checks++; if (bus.rf_we !== 1'b1 || bus.busy_mask !== 32'h6)
      $display("FAIL rst_pre: got we=%b busy=%h want 1 00000006", bus.rf_we, bus.busy_mask); else n_pass++;
    clear_inputs();
    #2 reset = 1'b1;
    #1;
    n_checks++; if (bus.rf_we !== 1'b0 || bus.busy_mask !== 32'h0)
      $display("FAIL rst_async: got we=%b busy=%h want 0 0", bus.rf_we, bus.busy_mask); else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    iss(1);
    n_checks++; if (o_we !== 1'b0 || o_busy !== 32'h0)
      $display("FAIL rst_no_write: got we=%b busy=%h want 0 0", o_we, o_busy); else n_pass++;
    iss(2);
    cycle(0, 0, 0, 0, 1, 1, 32'hA1, 1, 2, 32'hB2);
    n_checks++; if (o_ar !== 1'b1 || o_lr !== 1'b0)
      $display("FAIL rst_rr_alu_first: got alu=%b lsu=%b want 1 0", o_ar, o_lr); else n_pass++;
    cycle(0, 0, 0, 0, 0, 0, 32'h0, 1, 2, 32'hB2);
    n_checks++; if (o_lr !== 1'b1 || o_we !== 1'b1 || o_a3 !== 1 || o_wd3 !== 32'hA1)
      $display("FAIL rst_follow: got lsu=%b we=%b a3=%0d wd3=%h", o_lr, o_we, o_a3, o_wd3); else n_pass++;
    idle();
    idle();
    n_checks++; if (o_busy !== 32'h0) $display("FAIL rst_drain: got %h want 0", o_busy); else n_pass++;
  endtask

  task automatic test_random();
    int ia, il, av, lv, ard, lrd;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      av = 0; lv = 0; ard = 0; lrd = 0; ia = -1;
      if (pool.size() > 0 && $urandom_range(3) != 0) begin
        ia  = int'($urandom_range(pool.size() - 1));
        av  = 1;
        ard = pool[ia];
      end else if ($urandom_range(15) == 0) begin
        av = 1;
      end
      if (pool.size() > 0 && $urandom_range(3) != 0) begin
        il = int'($urandom_range(pool.size() - 1));
        if (il == ia) il = (il + 1) % pool.size();
        if (il != ia) begin
          lv  = 1;
          lrd = pool[il];
        end
      end else if ($urandom_range(15) == 0) begin
        lv = 1;
      end
      cycle(int'($urandom_range(1)), int'($urandom_range(31)), int'($urandom_range(31)),
            int'($urandom_range(31)), av, ard, $urandom, lv, lrd, $urandom);
      n_checks++; if (o_ir !== e_ir) $display("FAIL rnd_issue_ready@%0d: got %b want %b", n, o_ir, e_ir); else n_pass++;
      n_checks++; if (o_ar !== e_ar) $display("FAIL rnd_alu_ready@%0d: got %b want %b", n, o_ar, e_ar); else n_pass++;
      n_checks++; if (o_lr !== e_lr) $display("FAIL rnd_lsu_ready@%0d: got %b want %b", n, o_lr, e_lr); else n_pass++;
      n_checks++; if (o_we !== e_we) $display("FAIL rnd_we@%0d: got %b want %b", n, o_we, e_we); else n_pass++;
      n_checks++; if (o_busy !== e_busy) $display("FAIL rnd_busy@%0d: got %h want %h", n, o_busy, e_busy); else n_pass++;
      if (e_we) begin
        n_checks++; if (o_a3 !== e_a3 || o_wd3 !== e_wd3)
          $display("FAIL rnd_write@%0d: got a3=%0d wd3=%h want a3=%0d wd3=%h", n, o_a3, o_wd3, e_a3, e_wd3); else n_pass++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_raw_stall();
    test_rd_zero();
    test_alternation();
    test_waw();
    test_reset_after_grant();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
